// File: rtl/demod_ch_sched.sv
// Time-multiplexed channel scheduler for a shared phase-unwrap/differentiator datapath.
// Optional build macro DEMOD_CH_SCHED_PRIO_EN selects fixed priority (lowest channel wins) instead of round-robin.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no grants; waits for enable, flush here clears contexts
// RUN    | grants allowed, one handshake per cycle
// DRAIN  | no grants; waits for in-flight issues to return
// FLUSH  | no grants; waits for drain, then clears primed/context
module demod_ch_sched #(
    parameter int NCH    = 2,
    parameter int PW     = 12,
    parameter int DP_LAT = 3,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                flush,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*PW-1:0]   in_phase,
    output logic [NCH-1:0]      in_ready,
    output logic                dp_valid,
    output logic [PW-1:0]       dp_cur,
    output logic [PW-1:0]       dp_prev,
    input  logic [PW-1:0]       dp_result,
    output logic                out_valid,
    output logic [PW-1:0]       out_data,
    output logic [CH_W-1:0]     out_ch,
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

    state_t             state, state_nxt;
    logic [NCH-1:0]     primed;
    logic [PW-1:0]      ctx [NCH];
    logic               gnt_any;
    logic [CH_W-1:0]    gnt_idx;
    logic [PW-1:0]      gnt_phase;
    logic [CH_W-1:0]    dp_ch;
    logic [DP_LAT-1:0]  tag_v;
    logic [CH_W-1:0]    tag_ch [DP_LAT];
    logic               pipe_empty;
    logic               clr_ctx;
`ifndef DEMOD_CH_SCHED_PRIO_EN
    logic [CH_W-1:0]    rr_ptr;
`endif

    // Grant depends only on state, so a handshake in the cycle flush/enable changes still completes.
    always_comb begin
        int j;
        j         = 0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        in_ready  = '0;
        if (state == S_RUN) begin
`ifdef DEMOD_CH_SCHED_PRIO_EN
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CH_W'(i);
                end
            end
`else
            for (int i = 0; i < NCH; i++) begin
                j = int'(rr_ptr) + i;
                if (j >= NCH) j = j - NCH;
                if (!gnt_any && in_valid[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CH_W'(j);
                end
            end
`endif
        end
        if (gnt_any) in_ready[gnt_idx] = 1'b1;
    end

    assign gnt_phase  = in_phase[int'(gnt_idx)*PW +: PW];
    assign pipe_empty = !dp_valid && !(|tag_v);
    assign busy       = (state != S_IDLE) || !pipe_empty;

    always_comb begin
        state_nxt = state;
        clr_ctx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush)       clr_ctx   = 1'b1;
                else if (enable) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush)        state_nxt = S_FLUSH;
                else if (!enable) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (flush)           state_nxt = S_FLUSH;
                else if (pipe_empty) state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                if (pipe_empty) begin
                    clr_ctx   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            primed    <= '0;
            for (int i = 0; i < NCH; i++) ctx[i] <= '0;
`ifndef DEMOD_CH_SCHED_PRIO_EN
            rr_ptr    <= '0;
`endif
            dp_valid  <= 1'b0;
            dp_cur    <= '0;
            dp_prev   <= '0;
            dp_ch     <= '0;
            tag_v     <= '0;
            for (int i = 0; i < DP_LAT; i++) tag_ch[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            state    <= state_nxt;
            dp_valid <= gnt_any && primed[gnt_idx];
            if (gnt_any) begin
`ifndef DEMOD_CH_SCHED_PRIO_EN
                rr_ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
`endif
                if (primed[gnt_idx]) begin
                    dp_cur  <= gnt_phase;
                    dp_prev <= ctx[gnt_idx];
                    dp_ch   <= gnt_idx;
                end
                ctx[gnt_idx]    <= gnt_phase;
                primed[gnt_idx] <= 1'b1;
            end
            if (clr_ctx) begin
                primed <= '0;
                for (int i = 0; i < NCH; i++) ctx[i] <= '0;
            end
            // Tag stage i is visible DP_LAT-1-i cycles before the matching dp_result.
            tag_v[0]  <= dp_valid;
            tag_ch[0] <= dp_ch;
            for (int i = 1; i < DP_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
            out_valid <= tag_v[DP_LAT-1];
            if (tag_v[DP_LAT-1]) begin
                out_data <= dp_result;
                out_ch   <= tag_ch[DP_LAT-1];
            end
        end
    end

endmodule
